// File: rtl/fp_mult_arb_pkg.sv
// Shared types for the fp32 multiplier arbiter: FSM states, operand width
// and the in-flight tag-pipe entry.
package fp_mult_arb_pkg;

    localparam int unsigned FP32_W    = 32;
    // Tag field sized for the largest supported NUM_REQ (8); narrower configs zero-extend.
    localparam int unsigned TAG_MAX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 vld;
        logic [TAG_MAX_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr,
// wrapping modulo N, plus the binary index of that grant.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined fp32 multiplier among NUM_REQ requesters with round-robin
// grants, tag-routed results and drain handshake. Define FP_MULT_ARB_STATS_EN for grant/busy counters.
module fp_mult_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MULT_LAT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FP32_W-1:0] req_a,
    input  logic [NUM_REQ*FP32_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [FP32_W-1:0]         rsp_data,
    input  logic                      drain_req,
    output logic                      idle,
    output logic                      mult_en,
    output logic [FP32_W-1:0]         mult_a,
    output logic [FP32_W-1:0]         mult_b,
    input  logic [FP32_W-1:0]         mult_result
`ifdef FP_MULT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt,
    output logic [31:0]               busy_cnt
`endif
);

    localparam int unsigned TAG_W = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [TAG_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [TAG_W-1:0]   arb_idx;
    logic               grant_en;
    logic               xfer;
    logic               pipe_empty;
    tag_entry_t         new_entry;
    tag_entry_t         pipe [MULT_LAT+1];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // drain_req gates grants combinationally so a same-cycle drain beats a new request
    assign grant_en  = rst && (state != DRAIN) && !drain_req;
    assign req_ready = grant_en ? arb_grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign idle      = pipe_empty && (state != ACTIVE) && !(|req_ready);

    always_comb begin
        pipe_empty = 1'b1;
        for (int unsigned k = 0; k <= MULT_LAT; k++) begin
            if (pipe[k].vld) pipe_empty = 1'b0;
        end
    end

    always_comb begin
        new_entry = '0;
        if (xfer) begin
            new_entry.vld = 1'b1;
            new_entry.tag = TAG_MAX_W'(arb_idx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            mult_en   <= 1'b0;
            mult_a    <= '0;
            mult_b    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int unsigned k = 0; k <= MULT_LAT; k++) pipe[k] <= '0;
        end else begin
            case (state)
                IDLE:    if (drain_req) state <= DRAIN;
                         else if (|req_valid) state <= ACTIVE;
                ACTIVE:  if (drain_req) state <= DRAIN;
                         else if (!(|req_valid) && pipe_empty) state <= IDLE;
                DRAIN:   if (!drain_req && pipe_empty) state <= IDLE;
                default: state <= IDLE;
            endcase

            mult_en <= xfer;
            if (xfer) begin
                rr_ptr <= (arb_idx == TAG_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                mult_a <= req_a[arb_idx*FP32_W +: FP32_W];
                mult_b <= req_b[arb_idx*FP32_W +: FP32_W];
            end

            pipe[0] <= new_entry;
            for (int unsigned k = 1; k <= MULT_LAT; k++) pipe[k] <= pipe[k-1];

            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] <= pipe[MULT_LAT].vld && (pipe[MULT_LAT].tag == TAG_MAX_W'(i));
            end
            if (pipe[MULT_LAT].vld) rsp_data <= mult_result;
        end
    end

`ifdef FP_MULT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt <= '0;
            busy_cnt  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (xfer && (arb_idx == TAG_W'(i)) && (grant_cnt[16*i +: 16] != 16'hFFFF)) begin
                    grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
                end
            end
            if (mult_en) busy_cnt <= busy_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
Shares one pipelined fp32 multiplier (fixed latency MULT_LAT) among NUM_REQ requesters, such as systolic PE rows and the bias/scale unit, using round-robin arbitration.
Issues at most one operation per cycle and tags each in-flight operation with its requester index. Routes each result back to the owner with a one-cycle valid pulse.
Provides a drain/flush handshake so the array controller can quiesce the multiplier before reconfiguration.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MULT_LAT, 4, cycles from multiplier input sample to result register update
TAG_W, $clog2(NUM_REQ), requester index width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  one-hot grant; transfer = req_valid[i] & req_ready[i]
req_a  in  NUM_REQ*32  packed operand A, requester i at [32*i+:32]
req_b  in  NUM_REQ*32  packed operand B
rsp_valid  out  NUM_REQ  one-hot result pulse
rsp_data  out  32  result, shared by all requesters, qualified by rsp_valid
drain_req  in  1  stop granting and empty the pipe
idle  out  1  no in-flight operations and not granting
mult_en  out  1  multiplier input enable (registered)
mult_a  out  32  multiplier operand A (registered)
mult_b  out  32  multiplier operand B (registered)
mult_result  in  32  multiplier result

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, mult_en=0, mult_a=mult_b=0, idle=1, rr pointer=0, tag pipe cleared, state=IDLE.
- Reset asserted mid-operation discards all in-flight tags. No rsp_valid is produced for those operations.
- Arbitration:
  - req_ready is combinational: the first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready is all-zero in DRAIN.
  - On a transfer, rr_ptr <= granted index + 1 (wrapping). With no transfer, rr_ptr holds.
- Issue: on a transfer edge, mult_a/mult_b <= granted operands and mult_en <= 1. With no transfer, mult_en <= 0 and operands hold.
- Tag pipe: MULT_LAT+1 entries of {valid, tag}, shifting every cycle; stage 0 is loaded on a transfer edge.
- Response: rsp_valid[i] pulses exactly MULT_LAT+1 cycles after the acceptance edge, with rsp_data <= mult_result registered on the same edge. There is no response backpressure; requesters must accept.
- Throughput: one accept per cycle sustained. Back-to-back grants to the same requester are allowed when it is the only one valid.
- FSM:
  - IDLE -> ACTIVE on any req_valid, with no drain_req.
  - ACTIVE -> IDLE when no req_valid and the tag pipe is empty.
  - ACTIVE or IDLE -> DRAIN when drain_req=1.
  - DRAIN -> IDLE when drain_req=0 and the tag pipe is empty.
  - DRAIN holds while drain_req=1, even after the pipe is empty.
  - idle=1 iff the tag pipe is empty and state is not granting (IDLE, or DRAIN with an empty pipe).
- If drain_req and req_valid rise in the same cycle, drain wins and no grant is issued.
- Operand values are not inspected. Zero, infinity and overflow handling belong to the multiplier.

Optional Feature:
FP_MULT_ARB_STATS_EN:
- Defined: adds outputs grant_cnt (NUM_REQ*16) and busy_cnt (32).
  - grant_cnt[i] increments on each transfer from requester i and saturates at 16'hFFFF.
  - busy_cnt increments each cycle mult_en=1 and wraps.
  - Both counters reset to 0.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package fp_mult_arb_pkg holds:
  - the state enum (IDLE, ACTIVE, DRAIN);
  - the FP32_W=32 constant;
  - the tag-pipe entry typedef {logic vld; logic [TAG_W-1:0] tag}.
- One sub-module, rr_arbiter: parameterised round-robin grant with req/ptr in and one-hot grant out. It is reused later by the accumulator-sharing logic.

Test Plan:
- Single op: req_valid[0]=1, a=0x40400000 (3.0), b=0x40000000 (2.0) -> req_ready[0] same cycle; rsp_valid[0] after 5 cycles with rsp_data=0x40C00000.
- Fairness: all four requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each rsp_valid lands 5 cycles after its grant with the correct product and tag.
- Sparse requests: only requester 2 valid for 3 cycles -> 3 consecutive grants to 2 and 3 consecutive rsp_valid[2] pulses; rr_ptr=3 afterwards.
- Drain: 3 ops in flight, then drain_req=1 with all req_valid=1 -> no new grants; the 3 responses arrive; idle=1 after the last. Release drain -> grants resume from rr_ptr.
- Reset mid-op: assert rst low 2 cycles after a grant -> outputs at reset values; no rsp_valid after release; idle=1.
- Stats (macro defined): 10 grants to requester 1 and 5 to requester 3 -> grant_cnt[1]=10, grant_cnt[3]=5, busy_cnt=15.
